// File: rtl/cpu_mem_access.sv
// Memory-access stage: issues one data-bus load/store at a time with a ready
// handshake, optional timeout abort, and aligned sign/zero-extended load data.
module cpu_mem_access #(
  parameter int unsigned p_timeout = 255,  // 0 disables the timeout
  parameter int unsigned p_ld_buf  = 1     // 1: registered load result, 0: combinational
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_busy,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wr_data,
  output logic [3:0]  o_dbus_be,
  output logic        o_dbus_rd_en,
  output logic        o_dbus_wr_en,
  input  logic [31:0] i_dbus_rd_data,
  input  logic        i_dbus_ready,
  output logic [31:0] o_load_data,
  output logic        o_load_valid
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q;

  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        accept;
  logic        in_busy;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  // Decode the incoming request: alignment check, byte lanes and replicated store data.
  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b1111;
    req_wdata = i_wr_data;
    unique case (i_mem_size)
      2'b00: begin
        req_be    = 4'b0001 << i_addr[1:0];
        req_wdata = {4{i_wr_data[7:0]}};
      end
      2'b01: begin
        req_bad   = i_addr[0];
        req_be    = 4'b0011 << i_addr[1:0];
        req_wdata = {2{i_wr_data[15:0]}};
      end
      2'b10: begin
        req_bad = (i_addr[1:0] != 2'b00);
      end
      default: begin
        req_bad = 1'b1;
      end
    endcase
    // Loads drive no write data onto the bus.
    if (!i_mem_we) begin
      req_wdata = 32'h0;
    end
  end

  // Next-state logic: accept in IDLE, complete or time out in BUSY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    ld_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_mem_req) begin
          if (req_bad) begin
            mis_d = 1'b1;
          end else begin
            accept  = 1'b1;
            cnt_d   = 32'd0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (i_dbus_ready) begin
          ld_valid_d = ~we_q;
          state_d    = StIdle;
        end else if ((p_timeout != 0) && (cnt_q == p_timeout - 32'd1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Align the addressed lane down to bit 0 and extend to 32 bits.
  always_comb begin
    rd_shift = i_dbus_rd_data >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // Bus strobes and stall; bus fields are zeroed outside an access.
  always_comb begin
    in_busy        = (state_q == StBusy);
    // Gated by reset so every output reads 0 while reset is held.
    o_busy         = ~i_rst & (((state_q == StIdle) & i_mem_req & ~req_bad) |
                               (in_busy & ~i_dbus_ready));
    o_dbus_rd_en   = in_busy & ~we_q;
    o_dbus_wr_en   = in_busy & we_q;
    o_dbus_addr    = in_busy ? {addr_q[31:2], 2'b00} : 32'h0;
    o_dbus_be      = in_busy ? be_q : 4'h0;
    o_dbus_wr_data = in_busy ? wdata_q : 32'h0;
    o_misaligned   = mis_q;
    o_bus_err      = err_q;
    if (p_ld_buf != 0) begin
      o_load_valid = ld_valid_q;
      o_load_data  = ld_data_q;
    end else begin
      o_load_valid = ld_valid_d;
      o_load_data  = ld_valid_d ? ld_ext : 32'h0;
    end
  end

  // State, request latches, pulse flags and buffered load result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= 32'd0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
      ld_valid_q <= ld_valid_d;
      if (accept) begin
        addr_q  <= i_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        we_q    <= i_mem_we;
        size_q  <= i_mem_size;
        uns_q   <= i_mem_unsigned;
      end
      if (ld_valid_d) begin
        ld_data_q <= ld_ext;
      end
    end
  end

endmodule
